// File: rtl/decode_issue_stage.sv
// decode_issue_stage
//   Decode/issue stage sitting directly behind fetch. Classifies the fetched
//   pair into even/odd pipes, detects same-pipe and intra-pair RAW hazards,
//   dual-issues when legal, and otherwise splits the pair over two cycles in
//   program order while back-pressuring fetch.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   first_inst    program-order-first instruction from fetch
//   second_inst   program-order-second instruction from fetch
//   pc_in         address of first_inst (second_inst lives at pc_in + 4)
//   branch_taken  flush request from the branch unit
//   hold_in       downstream stall; freezes every register in this stage
//   stall_out     to fetch; fetch holds its outputs while high
//   even_inst     instruction issued to the even pipe (NOP_EVEN when empty)
//   even_valid    even_inst is a real instruction
//   odd_inst      instruction issued to the odd pipe (NOP_ODD when empty)
//   odd_valid     odd_inst is a real instruction
//   odd_pc        PC of the most recently issued odd instruction
//
// Bit numbering in the comments below is big-endian: bit 0 is inst[31].
module decode_issue_stage #(
    parameter int unsigned        INST_W   = 32,
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [INST_W-1:0]  NOP_EVEN = {11'b01000000001, 21'b0},
    parameter logic [INST_W-1:0]  NOP_ODD  = {11'b00000000001, 21'b0}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INST_W-1:0] first_inst,
    input  logic [INST_W-1:0] second_inst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              branch_taken,
    input  logic              hold_in,
    output logic              stall_out,
    output logic [INST_W-1:0] even_inst,
    output logic              even_valid,
    output logic [INST_W-1:0] odd_inst,
    output logic              odd_valid,
    output logic [ADDR_W-1:0] odd_pc
);

    typedef enum logic {
        StIdle,
        StSplit
    } state_e;

    // ------------------------------------------------------------------
    // Decode helpers (opcode is op[0:10] = inst[31:21])
    // ------------------------------------------------------------------
    function automatic logic is_empty(input logic [INST_W-1:0] inst);
        return (inst[INST_W-1 -: 11] == NOP_EVEN[INST_W-1 -: 11]) ||
               (inst[INST_W-1 -: 11] == NOP_ODD[INST_W-1 -: 11]);
    endfunction

    function automatic logic is_odd(input logic [INST_W-1:0] inst);
        logic [3:0] op4;
        op4 = inst[INST_W-1 -: 4];
        return (op4 == 4'b0010) || (op4 == 4'b0011) || (op4 == 4'b1011) ||
               (inst[INST_W-1 -: 8] == 8'b00111011);
    endfunction

    function automatic logic is_rrr(input logic [INST_W-1:0] inst);
        logic [3:0] op4;
        op4 = inst[INST_W-1 -: 4];
        return (op4 == 4'b1011) || (op4 == 4'b1100) || (op4 == 4'b1110) ||
               (op4 == 4'b1111);
    endfunction

    // RRR formats keep rt in bits [4:10]; everything else in [25:31].
    function automatic logic [6:0] rt_of(input logic [INST_W-1:0] inst);
        return is_rrr(inst) ? inst[27:21] : inst[6:0];
    endfunction

    // Conservative RAW: any source field of b matching a's target. No
    // write-enable qualification, so some false splits are expected.
    function automatic logic depends_on(input logic [INST_W-1:0] a,
                                        input logic [INST_W-1:0] b);
        logic [6:0] rt_a;
        rt_a = rt_of(a);
        return !is_empty(a) &&
               ((b[20:14] == rt_a) || (b[13:7] == rt_a) ||
                (is_rrr(b) && (b[6:0] == rt_a)));
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [INST_W-1:0]   even_inst_q, even_inst_d;
    logic                even_valid_q, even_valid_d;
    logic [INST_W-1:0]   odd_inst_q, odd_inst_d;
    logic                odd_valid_q, odd_valid_d;
    logic [ADDR_W-1:0]   odd_pc_q, odd_pc_d;
    logic [INST_W-1:0]   hold_inst_q, hold_inst_d;
    logic [ADDR_W-1:0]   hold_pc_q, hold_pc_d;

    logic                a_empty, b_empty, a_odd, b_odd, b_raw, hold_odd;
    logic [ADDR_W-1:0]   pc_b;

    assign a_empty  = is_empty(first_inst);
    assign b_empty  = is_empty(second_inst);
    assign a_odd    = is_odd(first_inst);
    assign b_odd    = is_odd(second_inst);
    assign b_raw    = depends_on(first_inst, second_inst);
    assign hold_odd = is_odd(hold_inst_q);
    assign pc_b     = pc_in + ADDR_W'(4);

    // ------------------------------------------------------------------
    // Next-state / issue logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        even_inst_d  = even_inst_q;
        even_valid_d = even_valid_q;
        odd_inst_d   = odd_inst_q;
        odd_valid_d  = odd_valid_q;
        odd_pc_d     = odd_pc_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;

        if (branch_taken) begin
            // Flush wins over hold and SPLIT; odd_pc keeps its last value.
            state_d      = StIdle;
            even_inst_d  = NOP_EVEN;
            even_valid_d = 1'b0;
            odd_inst_d   = NOP_ODD;
            odd_valid_d  = 1'b0;
            hold_inst_d  = '0;
            hold_pc_d    = '0;
        end else if (!hold_in) begin
            even_inst_d  = NOP_EVEN;
            even_valid_d = 1'b0;
            odd_inst_d   = NOP_ODD;
            odd_valid_d  = 1'b0;

            if (state_q == StSplit) begin
                // Second half of a split; the fetch pair on this edge is ignored.
                state_d     = StIdle;
                hold_inst_d = '0;
                hold_pc_d   = '0;
                if (hold_odd) begin
                    odd_inst_d  = hold_inst_q;
                    odd_valid_d = 1'b1;
                    odd_pc_d    = hold_pc_q;
                end else begin
                    even_inst_d  = hold_inst_q;
                    even_valid_d = 1'b1;
                end
            end else if (!a_empty && !b_empty && (a_odd != b_odd) && !b_raw) begin
                // Dual issue: each instruction to its own pipe regardless of slot.
                if (a_odd) begin
                    odd_inst_d  = first_inst;
                    odd_pc_d    = pc_in;
                    even_inst_d = second_inst;
                end else begin
                    even_inst_d = first_inst;
                    odd_inst_d  = second_inst;
                    odd_pc_d    = pc_b;
                end
                even_valid_d = 1'b1;
                odd_valid_d  = 1'b1;
            end else if (!a_empty) begin
                // A alone, either because B is empty or because the pair splits.
                if (a_odd) begin
                    odd_inst_d  = first_inst;
                    odd_valid_d = 1'b1;
                    odd_pc_d    = pc_in;
                end else begin
                    even_inst_d  = first_inst;
                    even_valid_d = 1'b1;
                end
                if (!b_empty) begin
                    state_d     = StSplit;
                    hold_inst_d = second_inst;
                    hold_pc_d   = pc_b;
                end
            end else if (!b_empty) begin
                if (b_odd) begin
                    odd_inst_d  = second_inst;
                    odd_valid_d = 1'b1;
                    odd_pc_d    = pc_b;
                end else begin
                    even_inst_d  = second_inst;
                    even_valid_d = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            even_inst_q  <= NOP_EVEN;
            even_valid_q <= 1'b0;
            odd_inst_q   <= NOP_ODD;
            odd_valid_q  <= 1'b0;
            odd_pc_q     <= '0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            even_inst_q  <= even_inst_d;
            even_valid_q <= even_valid_d;
            odd_inst_q   <= odd_inst_d;
            odd_valid_q  <= odd_valid_d;
            odd_pc_q     <= odd_pc_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign stall_out  = (state_q == StSplit) | hold_in;
    assign even_inst  = even_inst_q;
    assign even_valid = even_valid_q;
    assign odd_inst   = odd_inst_q;
    assign odd_valid  = odd_valid_q;
    assign odd_pc     = odd_pc_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage
//   Directed scenarios plus a randomized run against a queue-based issue model.
module tb_decode_issue_stage;

    localparam logic [31:0] NOP_EVEN = {11'b01000000001, 21'b0};
    localparam logic [31:0] NOP_ODD  = {11'b00000000001, 21'b0};
    localparam logic [31:0] ADD_R3   = {11'b00011000000, 7'd2, 7'd1, 7'd3};
    localparam logic [31:0] LQA_R4   = {9'b001100001, 16'd0, 7'd4};
    localparam logic [31:0] ADD_RAW  = {11'b00011000000, 7'd1, 7'd3, 7'd5};
    localparam logic [31:0] ADD_IND  = {11'b00011000000, 7'd7, 7'd6, 7'd8};

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] first_inst, second_inst, pc_in;
    logic        branch_taken, hold_in;
    logic        stall_out, even_valid, odd_valid;
    logic [31:0] even_inst, odd_inst, odd_pc;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    decode_issue_stage dut (
        .clock        (clock),
        .reset        (reset),
        .first_inst   (first_inst),
        .second_inst  (second_inst),
        .pc_in        (pc_in),
        .branch_taken (branch_taken),
        .hold_in      (hold_in),
        .stall_out    (stall_out),
        .even_inst    (even_inst),
        .even_valid   (even_valid),
        .odd_inst     (odd_inst),
        .odd_valid    (odd_valid),
        .odd_pc       (odd_pc)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model (big-endian field numbering) ----------
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } item_t;

    item_t       pend[$];
    logic [31:0] exp_even, exp_odd, exp_pc;
    logic        exp_ev, exp_ov;

    function automatic logic [31:0] fld(input logic [31:0] x, input int lo, input int hi);
        logic [31:0] mask;
        mask = (32'd1 << (hi - lo + 1)) - 32'd1;
        return (x >> (31 - hi)) & mask;
    endfunction

    function automatic logic f_empty(input logic [31:0] x);
        return fld(x, 0, 10) == fld(NOP_EVEN, 0, 10) || fld(x, 0, 10) == fld(NOP_ODD, 0, 10);
    endfunction

    function automatic logic f_odd(input logic [31:0] x);
        logic [31:0] o4;
        o4 = fld(x, 0, 3);
        return o4 == 2 || o4 == 3 || o4 == 11 || fld(x, 0, 7) == 32'h3B;
    endfunction

    function automatic logic f_rrr(input logic [31:0] x);
        logic [31:0] o4;
        o4 = fld(x, 0, 3);
        return o4 == 11 || o4 == 12 || o4 == 14 || o4 == 15;
    endfunction

    function automatic logic f_raw(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] rt;
        rt = f_rrr(a) ? fld(a, 4, 10) : fld(a, 25, 31);
        if (f_empty(a)) return 1'b0;
        return fld(b, 11, 17) == rt || fld(b, 18, 24) == rt ||
               (f_rrr(b) && fld(b, 25, 31) == rt);
    endfunction

    function automatic logic [31:0] gen_inst();
        int unsigned k;
        logic [31:0] x;
        k = $urandom_range(0, 9);
        x = {4'($urandom_range(0, 15)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)),
             7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
        if (k == 0) x = NOP_EVEN | (x & 32'h001F_FFFF);
        else if (k == 1) x = NOP_ODD | (x & 32'h001F_FFFF);
        return x;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_even = NOP_EVEN; exp_odd = NOP_ODD; exp_ev = 0; exp_ov = 0; exp_pc = 0;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] pc, input logic br, input logic hd);
        item_t items[$];
        item_t it;
        if (br) begin
            exp_even = NOP_EVEN; exp_odd = NOP_ODD; exp_ev = 0; exp_ov = 0;
            pend.delete();
        end else if (!hd) begin
            if (pend.size() > 0) begin
                items.push_back(pend.pop_front());
            end else begin
                if (!f_empty(a)) begin it.inst = a; it.pc = pc; items.push_back(it); end
                if (!f_empty(b)) begin it.inst = b; it.pc = pc + 4; items.push_back(it); end
                if (items.size() == 2 && (f_odd(a) == f_odd(b) || f_raw(a, b)))
                    pend.push_back(items.pop_back());
            end
            exp_even = NOP_EVEN; exp_odd = NOP_ODD; exp_ev = 0; exp_ov = 0;
            foreach (items[i]) begin
                if (f_odd(items[i].inst)) begin
                    exp_odd = items[i].inst; exp_ov = 1; exp_pc = items[i].pc;
                end else begin
                    exp_even = items[i].inst; exp_ev = 1;
                end
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset = 0; first_inst = NOP_EVEN; second_inst = NOP_ODD; pc_in = 0;
        branch_taken = 0; hold_in = 0;
        #3;
        checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin failures++;
            $display("FAIL reset_valids got=%b%b exp=00", even_valid, odd_valid); end
        @(negedge clock); reset = 1;
        repeat (3) cyc();
        checks++; if (even_inst !== NOP_EVEN) begin failures++;
            $display("FAIL reset_even got=%h exp=%h", even_inst, NOP_EVEN); end
        checks++; if (odd_inst !== NOP_ODD) begin failures++;
            $display("FAIL reset_odd got=%h exp=%h", odd_inst, NOP_ODD); end
        checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin failures++;
            $display("FAIL idle_valids got=%b%b exp=00", even_valid, odd_valid); end
        checks++; if (stall_out !== 1'b0) begin failures++;
            $display("FAIL reset_stall got=%b exp=0", stall_out); end
        checks++; if (odd_pc !== 32'h0) begin failures++;
            $display("FAIL reset_odd_pc got=%h exp=0", odd_pc); end
    endtask

    task automatic test_dual();
        first_inst = ADD_R3; second_inst = LQA_R4; pc_in = 32'h10;
        cyc();
        checks++; if (even_inst !== ADD_R3 || even_valid !== 1'b1) begin failures++;
            $display("FAIL dual_even got=%h/%b exp=%h/1", even_inst, even_valid, ADD_R3); end
        checks++; if (odd_inst !== LQA_R4 || odd_valid !== 1'b1) begin failures++;
            $display("FAIL dual_odd got=%h/%b exp=%h/1", odd_inst, odd_valid, LQA_R4); end
        checks++; if (odd_pc !== 32'h14) begin failures++;
            $display("FAIL dual_odd_pc got=%h exp=14", odd_pc); end
        checks++; if (stall_out !== 1'b0) begin failures++;
            $display("FAIL dual_stall got=%b exp=0", stall_out); end
    endtask

    task automatic test_raw_split();
        first_inst = ADD_R3; second_inst = ADD_RAW; pc_in = 32'h20;
        cyc();
        checks++; if (even_inst !== ADD_R3 || even_valid !== 1'b1 || odd_valid !== 1'b0) begin
            failures++; $display("FAIL raw_c1 got=%h/%b/%b exp=%h/1/0", even_inst, even_valid,
                                 odd_valid, ADD_R3); end
        checks++; if (stall_out !== 1'b1) begin failures++;
            $display("FAIL raw_c1_stall got=%b exp=1", stall_out); end
        checks++; if (odd_pc !== 32'h14) begin failures++;
            $display("FAIL raw_odd_pc_kept got=%h exp=14", odd_pc); end
        first_inst = LQA_R4; second_inst = ADD_R3; pc_in = 32'h30;
        cyc();
        checks++; if (even_inst !== ADD_RAW || even_valid !== 1'b1 || odd_valid !== 1'b0) begin
            failures++; $display("FAIL raw_c2 got=%h/%b/%b exp=%h/1/0", even_inst, even_valid,
                                 odd_valid, ADD_RAW); end
        checks++; if (stall_out !== 1'b0) begin failures++;
            $display("FAIL raw_c2_stall got=%b exp=0", stall_out); end
        cyc();
        checks++; if (even_inst !== ADD_R3 || odd_inst !== LQA_R4 || odd_valid !== 1'b1) begin
            failures++; $display("FAIL raw_c3 got=%h/%h/%b exp=%h/%h/1", even_inst, odd_inst,
                                 odd_valid, ADD_R3, LQA_R4); end
        checks++; if (odd_pc !== 32'h30) begin failures++;
            $display("FAIL raw_c3_odd_pc got=%h exp=30", odd_pc); end
    endtask

    task automatic test_same_pipe();
        first_inst = ADD_R3; second_inst = ADD_IND; pc_in = 32'h40;
        cyc();
        checks++; if (even_inst !== ADD_R3 || odd_valid !== 1'b0 || stall_out !== 1'b1) begin
            failures++; $display("FAIL same_c1 got=%h/%b/%b exp=%h/0/1", even_inst, odd_valid,
                                 stall_out, ADD_R3); end
        first_inst = NOP_EVEN; second_inst = NOP_ODD;
        cyc();
        checks++; if (even_inst !== ADD_IND || even_valid !== 1'b1 || stall_out !== 1'b0) begin
            failures++; $display("FAIL same_c2 got=%h/%b/%b exp=%h/1/0", even_inst, even_valid,
                                 stall_out, ADD_IND); end
        cyc();
        checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0) begin failures++;
            $display("FAIL same_c3 got=%b%b exp=00", even_valid, odd_valid); end
    endtask

    task automatic test_branch_split();
        first_inst = ADD_R3; second_inst = ADD_RAW; pc_in = 32'h60;
        cyc();
        checks++; if (stall_out !== 1'b1) begin failures++;
            $display("FAIL br_enter_split got=%b exp=1", stall_out); end
        branch_taken = 1;
        cyc();
        branch_taken = 0;
        checks++; if (even_valid !== 1'b0 || odd_valid !== 1'b0 || even_inst !== NOP_EVEN) begin
            failures++; $display("FAIL br_flush got=%h/%b%b exp=%h/00", even_inst, even_valid,
                                 odd_valid, NOP_EVEN); end
        checks++; if (stall_out !== 1'b0) begin failures++;
            $display("FAIL br_stall got=%b exp=0", stall_out); end
        first_inst = NOP_EVEN; second_inst = NOP_ODD;
        cyc();
        checks++; if (even_valid !== 1'b0) begin failures++;
            $display("FAIL br_b_dropped got=%b exp=0", even_valid); end
    endtask

    task automatic test_hold_async_reset();
        first_inst = ADD_R3; second_inst = ADD_RAW; pc_in = 32'h70;
        cyc();
        hold_in = 1; first_inst = NOP_EVEN; second_inst = NOP_ODD;
        repeat (2) cyc();
        checks++; if (even_inst !== ADD_R3 || even_valid !== 1'b1 || stall_out !== 1'b1) begin
            failures++; $display("FAIL hold_frozen got=%h/%b/%b exp=%h/1/1", even_inst,
                                 even_valid, stall_out, ADD_R3); end
        #2;
        hold_in = 0; reset = 0;
        #1;
        checks++; if (even_inst !== NOP_EVEN || even_valid !== 1'b0 || odd_pc !== 32'h0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%h exp=%h/0/0", even_inst,
                                 even_valid, odd_pc, NOP_EVEN); end
        checks++; if (stall_out !== 1'b0) begin failures++;
            $display("FAIL async_reset_stall got=%b exp=0", stall_out); end
        @(negedge clock); reset = 1;
        cyc();
        checks++; if (even_valid !== 1'b0 || stall_out !== 1'b0) begin failures++;
            $display("FAIL held_lost got=%b/%b exp=0/0", even_valid, stall_out); end
    endtask

    task automatic test_random();
        logic exp_stall;
        reset = 0; first_inst = NOP_EVEN; second_inst = NOP_ODD; pc_in = 0;
        branch_taken = 0; hold_in = 0;
        #3;
        @(negedge clock); reset = 1;
        model_reset();
        cyc();
        for (int n = 0; n < 500; n++) begin
            first_inst   = gen_inst();
            second_inst  = gen_inst();
            pc_in        = $urandom & 32'hFFFF_FFFC;
            branch_taken = ($urandom_range(0, 19) == 0);
            hold_in      = ($urandom_range(0, 4) == 0);
            #1;
            exp_stall = (pend.size() != 0) || hold_in;
            checks++; if (stall_out !== exp_stall) begin failures++;
                $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_out, exp_stall); end
            model_step(first_inst, second_inst, pc_in, branch_taken, hold_in);
            cyc();
            checks++; if (even_inst !== exp_even || even_valid !== exp_ev) begin failures++;
                $display("FAIL rnd_even n=%0d got=%h/%b exp=%h/%b", n, even_inst, even_valid,
                         exp_even, exp_ev); end
            checks++; if (odd_inst !== exp_odd || odd_valid !== exp_ov) begin failures++;
                $display("FAIL rnd_odd n=%0d got=%h/%b exp=%h/%b", n, odd_inst, odd_valid,
                         exp_odd, exp_ov); end
            checks++; if (odd_pc !== exp_pc) begin failures++;
                $display("FAIL rnd_odd_pc n=%0d got=%h exp=%h", n, odd_pc, exp_pc); end
        end
        branch_taken = 0; hold_in = 0;
    endtask

    initial begin
        test_reset();
        test_dual();
        test_raw_split();
        test_same_pipe();
        test_branch_split();
        test_hold_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- Sits directly downstream of the fetch stage. Consumes the fetched instruction pair (first_inst, second_inst) plus the pair PC.
- Classifies each instruction to the even or odd pipe and detects structural and intra-pair RAW hazards.
- Dual-issues when legal. Otherwise issues the pair in program order over two cycles and back-pressures fetch through stall_out.
- Honours branch flush and downstream hold.

Parameters:
- INST_W, 32, instruction width
- ADDR_W, 32, PC width
- NOP_EVEN, {11'b01000000001,21'b0}, even-pipe empty-slot encoding (nop)
- NOP_ODD, {11'b00000000001,21'b0}, odd-pipe empty-slot encoding (lnop)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- first_inst  in  32  program-order-first instruction from fetch
- second_inst  in  32  program-order-second instruction from fetch
- pc_in  in  32  address of first_inst; second_inst is at pc_in+4
- branch_taken  in  1  flush request from the branch unit
- hold_in  in  1  downstream stall
- stall_out  out  1  to fetch; fetch holds its outputs while high
- even_inst  out  32  instruction issued to the even pipe
- even_valid  out  1  even_inst is a real instruction
- odd_inst  out  32  instruction issued to the odd pipe
- odd_valid  out  1  odd_inst is a real instruction
- odd_pc  out  32  PC of odd_inst, used by the branch unit

Behaviour:
- Reset (reset=0, async):
  - even_inst=NOP_EVEN, odd_inst=NOP_ODD, even_valid=odd_valid=0, odd_pc=0.
  - Hold register cleared; FSM=IDLE; stall_out=0.
- Empty slot: an instruction equal to NOP_EVEN or NOP_ODD in op[0:10] is empty. It is never issued and never creates a hazard.
- Odd-class rule on op=inst[0:10]:
  - Odd if op[0:3]==4'b0010, or op[0:3]==4'b0011, or op[0:3]==4'b1011, or op[0:7]==8'b00111011.
  - Every other instruction is even.
- Register fields:
  - Generic formats: rb=[11:17], ra=[18:24], rt=[25:31].
  - RRR class (op[0:3] in {1011,1100,1110,1111}): rt=[4:10], rc=[25:31].
- RAW check: B depends on A if A is non-empty and any of B's ra, rb (or rc for RRR) equals A's rt. The check is conservative, with no write-enable qualification.
- Outputs are registered; latency is 1 cycle from pair acceptance to issue.
- FSM IDLE, pair A=first_inst, B=second_inst accepted at each edge with hold_in=0 and branch_taken=0:
  - Both empty: issue NOPs, valids 0.
  - Exactly one non-empty: route it to its pipe, valid=1; the other pipe gets its NOP, valid=0.
  - Different pipes, no RAW: dual issue; each instruction goes to its own pipe regardless of slot.
  - Same pipe or RAW: issue A only; latch B and pc_in+4 into the hold register; FSM goes to SPLIT.
- SPLIT:
  - stall_out=1 (combinational from state); fetch must not advance.
  - At the next edge (hold_in=0), issue B from the hold register and return to IDLE. The fetch pair present during SPLIT is not consumed.
- stall_out = (state==SPLIT) | hold_in.
- hold_in=1: all output registers, the hold register and the state freeze.
- branch_taken=1 at an edge:
  - Outputs become NOPs with valids 0; the hold register is discarded; FSM goes to IDLE.
  - Overrides hold_in and SPLIT. The input pair on that edge is dropped.
- odd_pc: pc_in, pc_in+4, or the held PC, whichever matches the issued odd instruction; unchanged when odd_valid=0.
- Reset asserted mid-SPLIT: immediate return to reset values; the held instruction is lost.

Test Plan:
1. Reset release, both inputs NOPs for 3 cycles -> even_inst=NOP_EVEN, odd_inst=NOP_ODD, valids 0, stall_out 0.
2. A={11'b00011000000,7'd2,7'd1,7'd3} (add r3), B={9'b001100001,16'd0,7'd4} (lqa r4), pc_in=0x10 -> next cycle even_inst=A, odd_inst=B, both valid, odd_pc=0x14, stall_out stays 0.
3. A=add r3, B={11'b00011000000,7'd1,7'd3,7'd5} (RAW on r3) -> cycle1 even_inst=A, odd_valid=0, stall_out=1; cycle2 even_inst=B, stall_out=0; the third fetch pair issues in cycle3.
4. A=add r3, B={11'b00011000000,7'd7,7'd6,7'd8} (same pipe, no RAW) -> split exactly as in scenario 3, over two cycles.
5. Enter SPLIT, assert branch_taken in the SPLIT cycle -> next cycle both valids 0, B never issued, stall_out=0.
6. hold_in=1 for 2 cycles during SPLIT, then reset=0 asynchronously mid-cycle -> outputs frozen while held; outputs reach reset values immediately, without waiting for a clock edge.
